i2c_read_sequencer: RTL
=======================

// Module: i2c_read_sequencer
// PURPOSE
//  Sequences a multi-byte register read through the I2C master, generalising the
//  two-byte MSB/LSB read controller. On a request pulse Z it drives enable P,
//  tracks the master's busy handshake per byte, and assembles NBYTES bytes MSB-first.
//  It presents the word atomically with a one-cycle valid strobe.
//  It sits between the sensor-polling logic (Z, data_out) and the I2C master (P, busy, data_rd).
// PARAMETERS
//  NBYTES          2     bytes per read, 1..8; data_out width = 8*NBYTES
//  HOLD_CYCLES     4     cycles P stays high after busy rises for the last byte, >=1
//  TIMEOUT_CYCLES  1023  max cycles in any busy-wait state before abort, >=1
// PORTS
//  CLK       in   1         system clock; all state updates on the falling edge
//  RST       in   1         asynchronous, active-low reset
//  Z         in   1         read request; level-sampled in IDLE only
//  busy      in   1         I2C master busy flag
//  data_rd   in   8         byte from the I2C master; stable from busy fall until next busy rise
//  P         out  1         enable/continue request to the I2C master
//  data_out  out  8*NBYTES  last completed word; first byte read in [8*NBYTES-1 -: 8]
//  valid     out  1         1-cycle pulse when data_out has just been loaded
//  active    out  1         high in every state except IDLE
//  err       out  1         1-cycle pulse on timeout abort
// BEHAVIOUR
//  - Reset (RST=0, async): state=IDLE; P=0, data_out=0, valid=0, active=0, err=0; counters=0.
//  - Outputs are registered (Moore). byte_idx counts 0..NBYTES-1, width $clog2(NBYTES+1).
//  - IDLE: P=0. If Z=1, go to WAIT_HI with byte_idx=0. P rises on the same edge.
//  - WAIT_HI: P=1. Waits for busy=1.
//      busy=1 and byte_idx<NBYTES-1: go to WAIT_LO.
//      busy=1 and byte_idx=NBYTES-1: go to HOLD.
//  - HOLD: P=1 for exactly HOLD_CYCLES cycles, then go to WAIT_LO with P=0.
//      This ends the read (NACK/stop). NBYTES=1 goes IDLE->WAIT_HI->HOLD.
//  - WAIT_LO: P=1 if byte_idx<NBYTES-1, else P=0. Waits for busy=0.
//  - On the first edge with busy=0 in WAIT_LO: shift data_rd into the internal
//      shift register (MSB-first) and increment byte_idx.
//      Then go to WAIT_HI, or to DONE if byte_idx was NBYTES-1.
//  - If busy already fell during HOLD, capture happens on the first WAIT_LO edge.
//  - DONE: load data_out from the shift register, valid=1 for one cycle, P=0, then IDLE.
//      A Z held high restarts on the following IDLE edge, so reads run back-to-back.
//  - data_out changes only in DONE and on reset; partial words are never visible.
//  - Z is ignored in every state except IDLE; no queuing.
//  - Timeout: a cycle counter clears on entry to WAIT_HI/WAIT_LO and counts each cycle
//      spent in them. On reaching TIMEOUT_CYCLES, go to ERR: P=0, err=1 for one cycle.
//      Then go to IDLE; data_out and valid are untouched.
//  - Reset mid-transfer: immediate IDLE with P=0. The I2C master handles its own recovery.
// CONFIGURATION
//  I2C_SEQ_TIMEOUT_EN defined: timeout counter, ERR state and err pulse are present.
//  Not defined: no counter or ERR state is built; wait states wait indefinitely; err is tied 0.
// TESTING
//  1. NBYTES=2, timeout enabled, busy model returns 0xA5 then 0x3C
//     -> data_out=16'hA53C, one valid pulse.
//     P high from the edge after Z until HOLD_CYCLES=4 cycles after the 2nd busy rise.
//  2. NBYTES=3, bytes 0x12,0x34,0x56 -> data_out=24'h123456.
//     data_out stays at its old value until the DONE edge.
//  3. After test 1, Z pulse with busy stuck 0 -> err pulses 1023 cycles after WAIT_HI entry.
//     P=0 and valid never pulses. data_out stays 16'hA53C.
//  4. RST=0 asserted mid-WAIT_LO of byte 0 -> P, valid and data_out are 0 without a clock edge.
//     After release, all outputs stay idle until Z.
//  5. Z held at 1 for 3 full reads -> 3 valid pulses, one DONE->IDLE->WAIT_HI gap each.
//     Z toggles mid-read have no effect.
//  6. Last-byte busy pulse of 2 cycles (falls inside HOLD), data_rd=0x7E
//     -> byte captured on the first WAIT_LO edge, LSB byte = 0x7E.

Source files
------------

// File: rtl/i2c_read_sequencer_if.sv
// Request/result and I2C-master handshake bundle for i2c_read_sequencer.
// master: the sequencer side; slave: the requester and I2C master side.
interface i2c_read_sequencer_if #(
   parameter int unsigned NBYTES = 2
);
   logic                Z;
   logic                busy;
   logic [7:0]          data_rd;
   logic                P;
   logic [8*NBYTES-1:0] data_out;
   logic                valid;
   logic                active;
   logic                err;

   modport master (
      input  Z, busy, data_rd,
      output P, data_out, valid, active, err
   );

   modport slave (
      output Z, busy, data_rd,
      input  P, data_out, valid, active, err
   );
endinterface

// File: rtl/i2c_read_sequencer.sv
// Multi-byte I2C register read sequencer: drives P, follows busy per byte, assembles the word MSB-first.
// Define I2C_SEQ_TIMEOUT_EN to build the wait-state timeout, ERR state and err pulse.
module i2c_read_sequencer #(
   parameter int unsigned NBYTES         = 2,
   parameter int unsigned HOLD_CYCLES    = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input logic                  CLK,
   input logic                  RST,
   i2c_read_sequencer_if.master bus
);
   localparam int unsigned DW = 8 * NBYTES;
   localparam int unsigned IW = $clog2(NBYTES + 1);
`ifdef I2C_SEQ_TIMEOUT_EN
   localparam int unsigned CMAX = (TIMEOUT_CYCLES > HOLD_CYCLES) ? TIMEOUT_CYCLES : HOLD_CYCLES;
`else
   localparam int unsigned CMAX = HOLD_CYCLES;
`endif
   localparam int unsigned CW = $clog2(CMAX + 1);

   localparam logic [IW-1:0] LAST_IDX  = IW'(NBYTES - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
`ifdef I2C_SEQ_TIMEOUT_EN
   localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
`endif

   typedef enum logic [2:0] {
      IDLE,
      WAIT_HI,
      HOLD,
      WAIT_LO,
`ifdef I2C_SEQ_TIMEOUT_EN
      ERR,
`endif
      DONE
   } state_t;

   state_t        state, state_n;
   logic [IW-1:0] byte_idx, idx_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [DW-1:0] shreg, sh_n;
   logic          counting;

`ifdef I2C_SEQ_TIMEOUT_EN
   assign counting = (state == HOLD) || (state == WAIT_HI) || (state == WAIT_LO);
`else
   assign counting = (state == HOLD);
`endif

   always_comb begin
      state_n = state;
      idx_n   = byte_idx;
      sh_n    = shreg;
      cnt_n   = cnt;
      unique case (state)
         IDLE: begin
            if (bus.Z) begin
               state_n = WAIT_HI;
               idx_n   = '0;
            end
         end
         WAIT_HI: begin
            if (bus.busy) state_n = (byte_idx == LAST_IDX) ? HOLD : WAIT_LO;
         end
         HOLD: begin
            if (cnt == HOLD_LAST) state_n = WAIT_LO;
         end
         WAIT_LO: begin
            if (!bus.busy) begin
               sh_n    = (shreg << 8) | DW'(bus.data_rd);
               idx_n   = byte_idx + 1'b1;
               state_n = (byte_idx == LAST_IDX) ? DONE : WAIT_HI;
            end
         end
         DONE: state_n = IDLE;
`ifdef I2C_SEQ_TIMEOUT_EN
         ERR:  state_n = IDLE;
`endif
         default: state_n = IDLE;
      endcase
`ifdef I2C_SEQ_TIMEOUT_EN
      // Abort only when the wait state would otherwise be kept on this edge
      if ((state == WAIT_HI || state == WAIT_LO) && (state_n == state) && (cnt == TO_LAST))
         state_n = ERR;
`endif
      if (state_n != state) cnt_n = '0;
      else if (counting)    cnt_n = cnt + 1'b1;
   end

   // Outputs are decoded from the next state so they line up with it (Moore, registered)
   always_ff @(negedge CLK or negedge RST) begin
      if (!RST) begin
         state        <= IDLE;
         byte_idx     <= '0;
         cnt          <= '0;
         shreg        <= '0;
         bus.P        <= 1'b0;
         bus.data_out <= '0;
         bus.valid    <= 1'b0;
         bus.active   <= 1'b0;
      end else begin
         state      <= state_n;
         byte_idx   <= idx_n;
         cnt        <= cnt_n;
         shreg      <= sh_n;
         bus.P      <= (state_n == WAIT_HI) || (state_n == HOLD) ||
                       ((state_n == WAIT_LO) && (idx_n < LAST_IDX));
         bus.valid  <= (state_n == DONE);
         bus.active <= (state_n != IDLE);
         if (state_n == DONE) bus.data_out <= sh_n;
      end
   end

`ifdef I2C_SEQ_TIMEOUT_EN
   always_ff @(negedge CLK or negedge RST) begin
      if (!RST) bus.err <= 1'b0;
      else      bus.err <= (state_n == ERR);
   end
`else
   assign bus.err = 1'b0;
`endif
endmodule
